// File: rtl/ts_packet_fifo_if.sv
// Byte-stream bus for ts_packet_fifo: write stream in, registered read stream and stats out.
interface ts_packet_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] wdata;
    logic                  valid_in;
    logic                  sop_in;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  valid_out;
    logic                  ready_in;
    logic                  sop_out;
    logic [ADDR_WIDTH:0]   pkt_count;
    logic [CNT_WIDTH-1:0]  drop_count;
    logic [CNT_WIDTH-1:0]  sync_err_count;

    // Upstream source / downstream sink side
    modport master (
        output wdata, valid_in, sop_in, ready_in,
        input  rdata, valid_out, sop_out, pkt_count, drop_count, sync_err_count
    );

    // FIFO side
    modport slave (
        input  wdata, valid_in, sop_in, ready_in,
        output rdata, valid_out, sop_out, pkt_count, drop_count, sync_err_count
    );
endinterface

// File: rtl/ts_packet_fifo.sv
// Packet-aware TS byte FIFO: stages bytes per packet, commits whole packets,
// drops and counts overflowing, short and unsynced packets.
module ts_packet_fifo #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           PKT_LEN    = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(8'h47),
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ts_packet_fifo_if.slave  bus
);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    wr_state_t             state, state_nxt;
    logic [PW-1:0]         wr_tmp, wr_tmp_nxt;
    logic [PW-1:0]         wr_cmt, wr_cmt_nxt;
    logic [PW-1:0]         byte_idx, byte_idx_nxt;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_idx;
    logic [PW-1:0]         base;
    logic                  sop_eval;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [1:0]            drop_add;
    logic                  sync_inc;
    logic                  commit;
    logic                  full_now;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  valid_q;
    logic                  sop_q;
    logic [PW-1:0]         pkt_count_q;
    logic [CNT_WIDTH-1:0]  drop_q;
    logic [CNT_WIDTH-1:0]  sync_q;

    logic                  load;
    logic                  last_load;
    logic                  drain;

    // Saturating counter increment
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + (CNT_WIDTH + 1)'(inc);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign full_now = ((wr_tmp - rd_ptr) == PW'(DEPTH));

    // Write FSM state register and staging/commit pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_tmp   <= '0;
            wr_cmt   <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            wr_tmp   <= wr_tmp_nxt;
            wr_cmt   <= wr_cmt_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    // Write FSM next state; a sop byte is always evaluated against the (possibly rewound) base
    always_comb begin
        state_nxt    = state;
        wr_tmp_nxt   = wr_tmp;
        wr_cmt_nxt   = wr_cmt;
        byte_idx_nxt = byte_idx;
        base         = wr_tmp;
        sop_eval     = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wr_tmp[ADDR_WIDTH-1:0];
        drop_add     = 2'd0;
        sync_inc     = 1'b0;
        commit       = 1'b0;

        case (state)
            IDLE, DISCARD: begin
                if (bus.valid_in && bus.sop_in) begin
                    sop_eval = 1'b1;
                end
            end
            FILL: begin
                if (bus.valid_in) begin
                    if (bus.sop_in) begin
                        // short packet: rewind, then treat this byte as a fresh start
                        wr_tmp_nxt = wr_cmt;
                        base       = wr_cmt;
                        drop_add   = 2'd1;
                        sop_eval   = 1'b1;
                    end else if (full_now) begin
                        wr_tmp_nxt = wr_cmt;
                        drop_add   = 2'd1;
                        state_nxt  = DISCARD;
                    end else begin
                        mem_we       = 1'b1;
                        mem_waddr    = wr_tmp[ADDR_WIDTH-1:0];
                        wr_tmp_nxt   = wr_tmp + PW'(1);
                        byte_idx_nxt = byte_idx + PW'(1);
                        if ((byte_idx + PW'(1)) == PW'(PKT_LEN)) begin
                            wr_cmt_nxt   = wr_tmp + PW'(1);
                            commit       = 1'b1;
                            byte_idx_nxt = '0;
                            state_nxt    = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (sop_eval) begin
            if (bus.wdata != SYNC_BYTE) begin
                sync_inc  = 1'b1;
                state_nxt = DISCARD;
            end else if ((base - rd_ptr) == PW'(DEPTH)) begin
                drop_add  = drop_add + 2'd1;
                state_nxt = DISCARD;
            end else begin
                mem_we       = 1'b1;
                mem_waddr    = base[ADDR_WIDTH-1:0];
                wr_tmp_nxt   = base + PW'(1);
                byte_idx_nxt = PW'(1);
                state_nxt    = FILL;
            end
        end
    end

    // Packet storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.wdata;
        end
    end

    assign load      = (!valid_q || bus.ready_in) && (rd_ptr != wr_cmt);
    assign last_load = load && (rd_idx == PW'(PKT_LEN - 1));
    assign drain     = valid_q && bus.ready_in && !load;

    // Registered read stage over committed bytes only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            rd_ptr  <= '0;
            rd_idx  <= '0;
        end else if (load) begin
            rdata_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            valid_q <= 1'b1;
            sop_q   <= (rd_idx == '0);
            rd_ptr  <= rd_ptr + PW'(1);
            rd_idx  <= last_load ? '0 : rd_idx + PW'(1);
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    // Committed-packet occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q <= '0;
        end else if (commit && !last_load) begin
            pkt_count_q <= pkt_count_q + PW'(1);
        end else if (last_load && !commit) begin
            pkt_count_q <= pkt_count_q - PW'(1);
        end
    end

    // Drop and sync-error statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            sync_q <= '0;
        end else begin
            drop_q <= sat_add(drop_q, drop_add);
            sync_q <= sat_add(sync_q, {1'b0, sync_inc});
        end
    end

    assign bus.rdata          = rdata_q;
    assign bus.valid_out      = valid_q;
    assign bus.sop_out        = sop_q;
    assign bus.pkt_count      = pkt_count_q;
    assign bus.drop_count     = drop_q;
    assign bus.sync_err_count = sync_q;

endmodule

// File: tb/tb_ts_packet_fifo.sv
// Scoreboard bench for ts_packet_fifo: directed packets, queue of expected bytes, negedge monitor.
module tb_ts_packet_fifo;
    localparam int unsigned PLEN = 188;

    typedef struct packed {
        logic       sop;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    int   ready_mode = 1;
    exp_t exp_q[$];

    logic       stalled = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_sop = 1'b0;

    ts_packet_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(16)) bus_if ();

    ts_packet_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(10), .PKT_LEN(PLEN), .SYNC_BYTE(8'h47), .CNT_WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] pkt_byte(input int seed, input int i);
        logic [7:0] b;
        b = (i == 0) ? 8'h47 : 8'(seed + i);
        return b;
    endfunction

    // Downstream ready: 0 = stall, 1 = always, otherwise pseudo-random
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus_if.ready_in = 1'b0;
            1:       bus_if.ready_in = 1'b1;
            default: bus_if.ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare every accepted byte and check hold stability while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(bus_if.valid_out), 32'd1);
                check("stall_rdata", 32'(bus_if.rdata), 32'(held_data));
                check("stall_sop", 32'(bus_if.sop_out), 32'(held_sop));
            end
            if (bus_if.valid_out && bus_if.ready_in) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", bus_if.rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdata", 32'(bus_if.rdata), 32'(e.data));
                    check("sop_out", 32'(bus_if.sop_out), 32'(e.sop));
                end
            end
            stalled   = bus_if.valid_out && !bus_if.ready_in;
            held_data = bus_if.rdata;
            held_sop  = bus_if.sop_out;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic sop);
        bus_if.valid_in = 1'b1;
        bus_if.wdata    = d;
        bus_if.sop_in   = sop;
        @(posedge clk);
        #1;
        bus_if.valid_in = 1'b0;
        bus_if.sop_in   = 1'b0;
    endtask

    task automatic send_pkt(input int seed, input int nbytes, input logic [7:0] first);
        for (int i = 0; i < nbytes; i++) begin
            send_byte((i == 0) ? first : pkt_byte(seed, i), i == 0);
        end
    endtask

    task automatic push_pkt(input int seed);
        for (int i = 0; i < int'(PLEN); i++) begin
            exp_t e;
            e.sop  = (i == 0);
            e.data = pkt_byte(seed, i);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        bus_if.valid_in = 1'b0;
        bus_if.sop_in   = 1'b0;
        bus_if.wdata    = '0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_if.valid_out) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus_if.valid_in = 1'b0;
        bus_if.sop_in   = 1'b0;
        bus_if.wdata    = '0;
        bus_if.ready_in = 1'b1;
        #1;
        // Reset state
        check("rst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("rst_sop_out", 32'(bus_if.sop_out), 32'd0);
        check("rst_rdata", 32'(bus_if.rdata), 32'd0);
        check("rst_pkt_count", 32'(bus_if.pkt_count), 32'd0);
        check("rst_drop", 32'(bus_if.drop_count), 32'd0);
        check("rst_sync", 32'(bus_if.sync_err_count), 32'd0);

        // Basic pass-through with latency
        ready_mode = 1;
        do_reset();
        push_pkt(0);
        send_pkt(0, PLEN, 8'h47);
        check("basic_valid_at_commit", 32'(bus_if.valid_out), 32'd0);
        check("basic_pkt_count_1", 32'(bus_if.pkt_count), 32'd1);
        @(posedge clk);
        #1;
        check("basic_valid_next", 32'(bus_if.valid_out), 32'd1);
        check("basic_first_sop", 32'(bus_if.sop_out), 32'd1);
        check("basic_first_byte", 32'(bus_if.rdata), 32'h47);
        wait_drain("basic_drain");
        check("basic_pkt_count_0", 32'(bus_if.pkt_count), 32'd0);

        // Overflow: 5 packets commit, 6th drops at its 85th byte
        ready_mode = 0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            push_pkt(10 + p);
            send_pkt(10 + p, PLEN, 8'h47);
        end
        send_pkt(15, PLEN, 8'h47);
        check("ovf_drop", 32'(bus_if.drop_count), 32'd1);
        check("ovf_pkt_count", 32'(bus_if.pkt_count), 32'd5);
        check("ovf_wr_tmp", 32'(dut.wr_tmp), 32'd940);
        check("ovf_wr_cmt", 32'(dut.wr_cmt), 32'd940);
        ready_mode = 1;
        wait_drain("ovf_drain");
        check("ovf_pkt_count_0", 32'(bus_if.pkt_count), 32'd0);

        // Short packet followed by a good one
        do_reset();
        send_pkt(20, 100, 8'h47);
        push_pkt(21);
        send_pkt(21, PLEN, 8'h47);
        check("short_drop", 32'(bus_if.drop_count), 32'd1);
        check("short_sync", 32'(bus_if.sync_err_count), 32'd0);
        wait_drain("short_drain");

        // Bad sync byte
        do_reset();
        send_pkt(30, PLEN, 8'h00);
        push_pkt(31);
        send_pkt(31, PLEN, 8'h47);
        check("badsync_sync", 32'(bus_if.sync_err_count), 32'd1);
        check("badsync_drop", 32'(bus_if.drop_count), 32'd0);
        wait_drain("badsync_drain");

        // Random backpressure across pointer wrap
        ready_mode = 2;
        do_reset();
        for (int p = 0; p < 20; p++) begin
            int n;
            n = 0;
            while (bus_if.pkt_count > 3 && n < 3000) begin
                @(posedge clk);
                #1;
                n++;
            end
            push_pkt(50 + 7 * p);
            send_pkt(50 + 7 * p, PLEN, 8'h47);
        end
        wait_drain("wrap_drain");
        check("wrap_drop", 32'(bus_if.drop_count), 32'd0);
        check("wrap_rd_ptr", 32'(dut.rd_ptr), 32'((20 * PLEN) % 2048));

        // Asynchronous reset mid-packet with valid_out high
        ready_mode = 0;
        do_reset();
        push_pkt(40);
        send_pkt(40, PLEN, 8'h47);
        send_pkt(41, 50, 8'h47);
        @(posedge clk);
        #1;
        check("arst_pre_valid", 32'(bus_if.valid_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("arst_sop_out", 32'(bus_if.sop_out), 32'd0);
        check("arst_rdata", 32'(bus_if.rdata), 32'd0);
        check("arst_pkt_count", 32'(bus_if.pkt_count), 32'd0);
        check("arst_drop", 32'(bus_if.drop_count), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        push_pkt(42);
        send_pkt(42, PLEN, 8'h47);
        wait_drain("arst_drain");
        check("arst_post_drop", 32'(bus_if.drop_count), 32'd0);
        check("arst_post_pkt_count", 32'(bus_if.pkt_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ts_packet_fifo.md
# ts_packet_fifo

Single-clock, packet-aware transport-stream byte FIFO for the QoS path. Bytes are staged per packet and committed to the read side only once a full `PKT_LEN`-byte packet has been written. Packets are dropped whole, and counted, when they overflow, arrive short or lack the sync byte. The read side is a registered valid/ready stream with a packet-start marker, feeding downstream QoS stages that must only ever see complete packets.

## Interface
- `DATA_WIDTH`, 8: byte width.
- `ADDR_WIDTH`, 10: depth = 2^ADDR_WIDTH entries.
- `PKT_LEN`, 188: bytes per packet; must satisfy 2 ≤ PKT_LEN ≤ 2^ADDR_WIDTH.
- `SYNC_BYTE`, 8'h47: required value of the first byte of every packet.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wdata`  in  DATA_WIDTH  input byte.
- `valid_in`  in  1  `wdata` valid this cycle; no backpressure.
- `sop_in`  in  1  first byte of a packet; qualified by `valid_in`.
- `rdata`  out  DATA_WIDTH  output byte, registered.
- `valid_out`  out  1  `rdata` valid.
- `ready_in`  in  1  downstream accepts `rdata` when `valid_out && ready_in`.
- `sop_out`  out  1  `rdata` is byte 0 of a packet.
- `pkt_count`  out  ADDR_WIDTH+1  committed packets not yet fully read.
- `drop_count`  out  CNT_WIDTH  packets dropped (overflow or short), saturating.
- `sync_err_count`  out  CNT_WIDTH  packets dropped for a bad sync byte, saturating.

## Operation
- **Pointers.** Three pointers, each ADDR_WIDTH+1 bits and wrapping modulo 2^(ADDR_WIDTH+1):
  - `wr_tmp` (staging);
  - `wr_cmt` (committed);
  - `rd_ptr`.
  - Used = `wr_tmp - rd_ptr`. Full when used == DEPTH.
- **Write FSM.** States are IDLE, FILL and DISCARD.
  - IDLE: on `valid_in && sop_in`:
    - if `wdata == SYNC_BYTE` and not full, write the byte, set byte_idx = 1 and go to FILL;
    - if `wdata != SYNC_BYTE`, increment `sync_err_count` and go to DISCARD;
    - if full, increment `drop_count` and go to DISCARD.
  - IDLE: `valid_in` without `sop_in` is ignored.
  - FILL, `valid_in && !sop_in`:
    - if full, set `wr_tmp ← wr_cmt`, increment `drop_count`, go to DISCARD;
    - else write the byte and increment byte_idx;
    - when byte_idx reaches PKT_LEN, set `wr_cmt ← wr_tmp+1` in the same edge and go to IDLE.
  - FILL, `valid_in && sop_in` (short packet): set `wr_tmp ← wr_cmt` and increment `drop_count`. The sop byte is then evaluated exactly as in IDLE in the same cycle, using post-rewind fullness.
  - DISCARD: ignore bytes until `valid_in && sop_in`, then evaluate as IDLE in the same cycle.
- **Read side.**
  - Only bytes in [rd_ptr, wr_cmt) are readable.
  - Load condition: `(!valid_out || ready_in) && rd_ptr != wr_cmt`. On load: `rdata ← mem[rd_ptr]`, `rd_ptr++`, `valid_out ← 1`, and `sop_out ← (rd_idx == 0)`.
  - rd_idx counts 0..PKT_LEN-1 and wraps.
  - If `ready_in && valid_out` and there is nothing to load, `valid_out ← 0`.
  - `rdata` and `sop_out` hold while `valid_out && !ready_in`.
- **pkt_count.** +1 on commit, −1 when the last byte of a packet (rd_idx == PKT_LEN-1) is loaded. Both events in the same cycle leave it unchanged.
- **Counters.** Saturate at all-ones.
- **Reset.** Returns the FSM to IDLE. All pointers, byte_idx, rd_idx and counters go to 0. `valid_out`, `sop_out` and `rdata` go to 0. Memory contents are don't-care.

## Timing
- All state updates on `posedge clk`. Reset acts immediately and asynchronously; release it synchronously upstream.
- **Latency.** The last byte of a packet is accepted at edge k and commits at edge k. The first byte loads at edge k+1, so `valid_out` is high after k+1 when the FIFO was previously empty.
- **Streaming.** With `ready_in` held high, one byte per cycle streams out with no bubbles between committed packets.
- **Same-cycle write and read.** A write and a read in the same cycle are both allowed. Fullness uses pre-edge pointers, so a read in that cycle does not free space for that cycle's write.
- **Reset mid-packet.** The staged partial packet is lost; it is not counted as a drop.

## Test plan
- **Basic pass-through.** Reset, then write one 188-byte packet (0x47, 1..187) with `ready_in`=1.
  - `valid_out` rises 1 cycle after the last write.
  - 188 bytes come out in order, `sop_out` is high only with 0x47, and `pkt_count` goes 0→1→0.
- **Overflow.** Write 6 back-to-back packets with `ready_in`=0 (depth 1024).
  - Packets 1–5 commit (940 bytes).
  - Packet 6 drops at its 85th byte: `drop_count`=1, `pkt_count`=5, `wr_tmp == wr_cmt`.
  - Draining yields exactly 5 intact packets.
- **Short packet.** Write 100 bytes, then `sop_in` with 0x47 followed by a full packet.
  - `drop_count`=1.
  - Exactly one packet is output, and it matches the second packet.
- **Bad sync.** Start a packet with 0x00, then write a good packet.
  - `sync_err_count`=1, `drop_count`=0.
  - Only the good packet is output.
- **Backpressure and wrap.** Stream 20 packets with `ready_in` toggling pseudo-randomly.
  - No loss and no duplication across pointer wrap.
  - `rdata` and `sop_out` are stable while stalled.
- **Async reset mid-stream.** Assert `rst_n`=0 mid-packet with `valid_out`=1.
  - All outputs are 0 without waiting for a clock edge.
  - After release, a new packet passes normally.
